// File: rtl/encode32_scan.sv
// encode32_scan: sequential 32-to-5 scanning encoder.
// Accepts a mask and emits the index of every set bit, lowest first,
// one per out_valid/out_ready handshake. A zero mask completes at once.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_valid/load_ready mask offer / block idle and able to accept
//   load_mask             mask to scan
//   out_valid/out_ready   index handshake
//   out_sel               lowest set index of the remaining mask
//   out_last              current index is the final one
//   remaining_cnt         popcount of remaining mask (0 when idle)
//   done                  one-cycle pulse when a scan completes
module encode32_scan #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SEL_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [WIDTH-1:0]    load_mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_BITS-1:0] out_sel,
  output logic                out_last,
  output logic [SEL_BITS:0]   remaining_cnt,
  output logic                done
);

  localparam int unsigned CNT_BITS = SEL_BITS + 1;

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic                done_q, done_d;

  logic [SEL_BITS-1:0] sel_c;
  logic [CNT_BITS-1:0] cnt_c;

  // Priority encode: scanning from the top down lets the lowest set bit win.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (rem_q[SEL_BITS'(i - 1)]) begin
        sel_c = SEL_BITS'(i - 1);
      end
    end
  end

  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_c = cnt_c + CNT_BITS'(rem_q[SEL_BITS'(i)]);
    end
  end

  assign load_ready    = (state_q == IDLE);
  assign out_valid     = (state_q == SCAN);
  assign out_sel       = sel_c;
  assign remaining_cnt = (state_q == SCAN) ? cnt_c : '0;
  assign out_last      = (remaining_cnt == CNT_BITS'(1));
  assign done          = done_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          if (|load_mask) begin
            rem_d   = load_mask;
            state_d = SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (out_ready) begin
          // rem & (rem - 1) clears exactly the lowest set bit, i.e. out_sel.
          rem_d = rem_q & (rem_q - WIDTH'(1));
          if (out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_encode32_scan.sv
// Testbench for encode32_scan: directed steps with an expected-index queue.
module tb_encode32_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sel;
  logic        out_last;
  logic [5:0]  remaining_cnt;
  logic        done;

  encode32_scan #(.WIDTH(32), .SEL_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_mask    (load_mask),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sel      (out_sel),
    .out_last     (out_last),
    .remaining_cnt(remaining_cnt),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] sel;
    logic       last;
    logic [5:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic exp_done = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check outputs of this cycle, predict the
  // effect of the coming rising edge, then advance one cycle.
  task automatic tick();
    logic        nd;
    bit          was_idle;
    exp_t        e;
    int unsigned n;
    nd       = 1'b0;
    was_idle = (sb.size() == 0);
    chk("done", done, exp_done);
    chk("out_valid", out_valid, !was_idle);
    chk("load_ready", load_ready, was_idle);
    if (!was_idle) begin
      e = sb[0];
      chk("out_sel", out_sel, e.sel);
      chk("out_last", out_last, e.last);
      chk("remaining_cnt", remaining_cnt, e.cnt);
      if (out_ready) begin
        if (e.last) nd = 1'b1;
        void'(sb.pop_front());
      end
    end else begin
      chk("idle_out_sel", out_sel, 0);
      chk("idle_out_last", out_last, 0);
      chk("idle_remaining_cnt", remaining_cnt, 0);
    end
    if (was_idle && load_valid) begin
      n = $countones(load_mask);
      if (n == 0) nd = 1'b1;
      for (int i = 0; i < 32; i++) begin
        if (load_mask[i]) begin
          e.sel  = 5'(i);
          e.cnt  = 6'(n);
          e.last = (n == 1);
          sb.push_back(e);
          n--;
        end
      end
    end
    if (reset) begin
      sb.delete();
      nd = 1'b0;
    end
    exp_done = nd;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] m);
    load_valid = 1'b1;
    load_mask  = m;
    tick();
    load_valid = 1'b0;
    load_mask  = '0;
  endtask

  // Run until the queue is empty and any pending done has been checked.
  task automatic drain();
    for (int i = 0; i < 40 && (sb.size() != 0 || exp_done); i++) tick();
    chk("drain_timeout", (sb.size() == 0 && !exp_done), 1);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_mask  = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();

    // one-hot limit
    out_ready = 1'b1;
    load(32'h0000_0001);
    drain();

    // sparse
    load(32'h8000_0011);
    drain();

    // full
    load(32'hFFFF_FFFF);
    drain();

    // backpressure
    out_ready = 1'b0;
    load(32'h0000_0500);
    repeat (3) tick();
    out_ready = 1'b1;
    drain();

    // zero mask
    load(32'h0000_0000);
    drain();

    // load offered during a scan is ignored
    load(32'h0000_00F0);
    load_valid = 1'b1;
    load_mask  = 32'hFFFF_0000;
    tick();
    tick();
    load_valid = 1'b0;
    load_mask  = '0;
    drain();

    // reset mid-scan
    load(32'h0000_FFFF);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    load(32'h0000_0004);
    drain();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
